// File: rtl/fetch_prefetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_unit
//
// Instruction-fetch front end with a DEPTH-entry prefetch buffer.
// The unit owns the fetch PC and issues reads to a synchronous instruction
// memory that has a 1-cycle read latency. Each returned word is queued with its
// PC and handed to decode over a valid/ready handshake. A redirect loads a new
// fetch PC, flushes the buffer and squashes the read that is returning.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   defined   : stall and redirect counters are built (saturating, CNT_W bits)
//   undefined : both counter ports are tied to 0
//
// Ports
//   clk_i          in   1        CPU clock, rising edge
//   reset_b_i      in   1        asynchronous active-low reset
//   redirect_i     in   1        load redirect_pc_i as the fetch PC and flush
//   redirect_pc_i  in   PC_W     redirect target (low alignment bits ignored)
//   imem_req_o     out  1        read issued this cycle
//   imem_addr_o    out  PC_W     read address (the fetch PC register)
//   imem_data_i    in   INSTR_W  read data, valid the cycle after imem_req_o
//   instr_valid_o  out  1        buffer head is valid
//   instr_ready_i  in   1        decode accepts the head this cycle
//   instr_o        out  INSTR_W  head instruction
//   instr_pc_o     out  PC_W     PC of the head instruction
//   stall_cnt_o    out  CNT_W    cycles with valid & ~ready
//   redirect_cnt_o out  CNT_W    redirects accepted
// -----------------------------------------------------------------------------
module fetch_prefetch_unit #(
  parameter int              PC_W         = 32,
  parameter int              INSTR_W      = 32,
  parameter int              INSTR_BYTES  = 4,
  parameter int              DEPTH        = 4,
  parameter logic [PC_W-1:0] RESET_VECTOR = {PC_W{1'b0}},
  parameter int              CNT_W        = 16
) (
  input  logic               clk_i,
  input  logic               reset_b_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    instr_pc_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   redirect_cnt_o
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C    = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]  CNT_ONE    = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PC_W-1:0] PC_INC     = PC_W'(INSTR_BYTES);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(INSTR_BYTES - 1));

  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    pending_pc_q, pending_pc_d;
  logic               inflight_q, inflight_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [INSTR_W-1:0] data_mem_q [DEPTH];
  logic [PC_W-1:0]    pc_mem_q   [DEPTH];

  logic [PTR_W:0]     credit_used_s;
  logic               valid_s;
  logic               issue_s;
  logic               push_s;
  logic               pop_s;

  // Issue/return/pop decisions and next-state for PC, pointers and count
  always_comb begin
    // Entries held plus the read still returning: a credit scheme that keeps
    // the buffer from ever overflowing.
    credit_used_s = count_q + {{PTR_W{1'b0}}, inflight_q};
    valid_s       = (count_q != {(PTR_W + 1){1'b0}});
    issue_s       = ~redirect_i & (credit_used_s < DEPTH_C);
    // A word returning in a redirect cycle belongs to the old stream.
    push_s        = inflight_q & ~redirect_i;
    pop_s         = valid_s & instr_ready_i;

    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    inflight_d   = inflight_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ALIGN_MASK;
      inflight_d = 1'b0;
      wr_ptr_d   = {PTR_W{1'b0}};
      rd_ptr_d   = {PTR_W{1'b0}};
      count_d    = {(PTR_W + 1){1'b0}};
    end else begin
      inflight_d = issue_s;
      if (issue_s) begin
        pending_pc_d = fetch_pc_q;
        fetch_pc_d   = fetch_pc_q + PC_INC;
      end else begin
        pending_pc_d = pending_pc_q;
        fetch_pc_d   = fetch_pc_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk_i or negedge reset_b_i) begin
    if (!reset_b_i) begin
      fetch_pc_q   <= RESET_VECTOR;
      pending_pc_q <= {PC_W{1'b0}};
      inflight_q   <= 1'b0;
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {(PTR_W + 1){1'b0}};
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Buffer storage: returned word and its PC written at the tail
  always_ff @(posedge clk_i or negedge reset_b_i) begin
    if (!reset_b_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= {INSTR_W{1'b0}};
        pc_mem_q[i]   <= {PC_W{1'b0}};
      end
    end else if (push_s) begin
      data_mem_q[wr_ptr_q] <= imem_data_i;
      pc_mem_q[wr_ptr_q]   <= pending_pc_q;
    end else begin
      data_mem_q[wr_ptr_q] <= data_mem_q[wr_ptr_q];
      pc_mem_q[wr_ptr_q]   <= pc_mem_q[wr_ptr_q];
    end
  end

  // Request is held low for the whole time reset is asserted; the state path
  // does not need this gating because every register is held in reset.
  assign imem_req_o    = issue_s & reset_b_i;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = valid_s;
  assign instr_o       = data_mem_q[rd_ptr_q];
  assign instr_pc_o    = pc_mem_q[rd_ptr_q];

`ifdef FETCH_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

  // Saturating next-state for the performance counters
  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (valid_s && !instr_ready_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_INC;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (redirect_i && (redirect_cnt_q != CNT_MAX)) begin
      redirect_cnt_d = redirect_cnt_q + CNT_INC;
    end else begin
      redirect_cnt_d = redirect_cnt_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk_i or negedge reset_b_i) begin
    if (!reset_b_i) begin
      stall_cnt_q    <= {CNT_W{1'b0}};
      redirect_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign stall_cnt_o    = stall_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
`else
  assign stall_cnt_o    = {CNT_W{1'b0}};
  assign redirect_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_prefetch_unit
//
// Directed and randomized stimulus for fetch_prefetch_unit. A transaction-level
// reference (queue of expected PCs, one outstanding read, saturating counters)
// predicts every output once per cycle. The emulated instruction memory
// returns memf(addr) one cycle after a request and random garbage otherwise.
// -----------------------------------------------------------------------------
module tb_fetch_prefetch_unit;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic        clk_i = 1'b0;
  logic        reset_b_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] redirect_cnt_o;

  always #5 clk_i = ~clk_i;

  fetch_prefetch_unit #(
    .PC_W(32), .INSTR_W(32), .INSTR_BYTES(4), .DEPTH(DEPTH),
    .RESET_VECTOR(32'h0000_0000), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .reset_b_i(reset_b_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .stall_cnt_o(stall_cnt_o), .redirect_cnt_o(redirect_cnt_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [31:0] m_pc;
  bit          m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_q[$];
  int          m_stall;
  int          m_redir;
  bit          ret_valid;
  logic [31:0] ret_addr;
  int          req_seen;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0000_0000;
    m_infl    = 1'b0;
    m_infl_pc = 32'h0000_0000;
    m_q.delete();
    m_stall   = 0;
    m_redir   = 0;
    ret_valid = 1'b0;
    ret_addr  = 32'h0000_0000;
  endtask

  // One clock cycle: entered just after a falling edge, leaves at the next one.
  task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy);
    logic exp_req;
    logic exp_valid;
    logic pop;
    imem_data_i   = ret_valid ? memf(ret_addr) : $urandom;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    instr_ready_i = rdy;
    #1;
    exp_valid = (m_q.size() != 0);
    exp_req   = !redir && ((m_q.size() + int'(m_infl)) < DEPTH);
    chk("req",   {31'd0, imem_req_o},    {31'd0, exp_req});
    chk("addr",  imem_addr_o,            m_pc);
    chk("valid", {31'd0, instr_valid_o}, {31'd0, exp_valid});
    if (exp_valid) begin
      chk("instr_pc", instr_pc_o, m_q[0]);
      chk("instr",    instr_o,    memf(m_q[0]));
    end
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt", {28'd0, stall_cnt_o},    m_stall);
    chk("redir_cnt", {28'd0, redirect_cnt_o}, m_redir);
`else
    chk("stall_cnt", {28'd0, stall_cnt_o},    32'd0);
    chk("redir_cnt", {28'd0, redirect_cnt_o}, 32'd0);
`endif
    if (imem_req_o === 1'b1) req_seen++;

    // Advance the reference across the rising edge
    pop = exp_valid && rdy;
    if (exp_valid && !rdy && m_stall < CMAX) m_stall++;
    if (redir && m_redir < CMAX) m_redir++;
    ret_valid = exp_req;
    ret_addr  = m_pc;
    if (redir) begin
      m_q.delete();
      m_infl = 1'b0;
      m_pc   = rpc & 32'hFFFF_FFFC;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_pc);
      if (exp_req) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
      m_infl = exp_req;
    end
    @(negedge clk_i);
  endtask

  initial begin
    reset_b_i     = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0000_0000;
    instr_ready_i = 1'b0;
    imem_data_i   = 32'h0000_0000;
    model_reset();

    // Reset state
    @(negedge clk_i);
    #1;
    chk("rst_req",   {31'd0, imem_req_o},    32'd0);
    chk("rst_addr",  imem_addr_o,            32'h0000_0000);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o,                32'h0000_0000);
    chk("rst_pc",    instr_pc_o,             32'h0000_0000);
    chk("rst_stall", {28'd0, stall_cnt_o},   32'd0);
    chk("rst_redir", {28'd0, redirect_cnt_o}, 32'd0);
    @(negedge clk_i);
    reset_b_i = 1'b1;

    // Decode stalled from the start: only DEPTH reads may be issued
    req_seen = 0;
    repeat (20) step(1'b0, 32'h0, 1'b0);
    chk("full_reqs", req_seen, DEPTH);
    repeat (12) step(1'b0, 32'h0, 1'b1);

    // Redirect to an unaligned target while a read is returning
    step(1'b1, 32'h0000_0103, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1);

    // Back-to-back redirects: the last one wins
    step(1'b1, 32'h0000_0200, 1'b1);
    step(1'b1, 32'h0000_0300, 1'b0);
    repeat (6) step(1'b0, 32'h0, 1'b1);

    // PC wrap-around at the top of the address space
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1);

    // Randomized traffic
    repeat (300) step(($urandom % 16) == 0, $urandom, ($urandom % 4) != 0);

    // Asynchronous reset with the buffer partially full
    step(1'b1, 32'h0000_0040, 1'b0);
    repeat (4) step(1'b0, 32'h0, 1'b0);
    chk("pre_rst_valid", {31'd0, instr_valid_o}, 32'd1);
    #2;
    reset_b_i = 1'b0;
    #1;
    chk("async_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("async_req",   {31'd0, imem_req_o},    32'd0);
    chk("async_addr",  imem_addr_o,            32'h0000_0000);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    reset_b_i = 1'b1;
    repeat (10) step(1'b0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
